v_exec_ctrl: RTL and testbench

Sequencing controller for the combinational vector ALU (`v_execute`). It accepts one decoded vector ALU instruction at a time over a valid/ready handshake and reads both source vector registers from the vector register file. It then holds stable registered operands and opcode on the ALU for one cycle, or for `DIV_LAT` cycles on `VDIV`, and writes the result back to `vd`. It sits between the vector decode stage and the `v_execute` / vector-register-file pair inside the vector unit.

---
 rtl/v_exec_ctrl_pkg.sv | 37 +++
 rtl/v_exec_ctrl.sv | 148 ++++++++++++++
 tb/tb_v_exec_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_exec_ctrl_pkg.sv
// Shared definitions for the vector execute controller: geometry, ALU opcodes and FSM states.
// The opcode encodings must match the ones used by v_execute.
package v_exec_ctrl_pkg;

  localparam int VREG_WIDTH = 128;
  localparam int SEW        = 32;
  localparam int VLMAX      = VREG_WIDTH / SEW;
  localparam int ALU_OP_BUS = 5;

  typedef logic [ALU_OP_BUS-1:0] valu_op_t;

  localparam valu_op_t VALU_OP_NOP     = 5'd0;
  localparam valu_op_t VALU_OP_VADD    = 5'd1;
  localparam valu_op_t VALU_OP_VSUB    = 5'd2;
  localparam valu_op_t VALU_OP_VMUL    = 5'd3;
  localparam valu_op_t VALU_OP_VDIV    = 5'd4;
  localparam valu_op_t VALU_OP_VAND    = 5'd5;
  localparam valu_op_t VALU_OP_VOR     = 5'd6;
  localparam valu_op_t VALU_OP_VXOR    = 5'd7;
  localparam valu_op_t VALU_OP_VREDSUM = 5'd8;
  localparam valu_op_t VALU_OP_VREDMAX = 5'd9;
  localparam valu_op_t VALU_OP_VMV_V_X = 5'd10;

  typedef enum logic [2:0] {
    VCTRL_IDLE  = 3'd0,
    VCTRL_READ  = 3'd1,
    VCTRL_LATCH = 3'd2,
    VCTRL_EXEC  = 3'd3,
    VCTRL_WB    = 3'd4
  } vctrl_state_e;

  // Only the divider is multi-cycle; every other op gets a single EXEC cycle.
  function automatic logic is_div(input valu_op_t op);
    return op == VALU_OP_VDIV;
  endfunction

endpackage

// File: rtl/v_exec_ctrl.sv
// Sequences one vector ALU instruction at a time: register-file read, operand latch,
// held EXEC window for the combinational ALU, then writeback to vd.
module v_exec_ctrl
  import v_exec_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 4,
  parameter int VREG_W  = VREG_WIDTH,
  parameter int ELEM_W  = SEW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [ALU_OP_BUS-1:0] issue_op_i,
  input  logic [4:0]            issue_vs1_i,
  input  logic [4:0]            issue_vs2_i,
  input  logic [4:0]            issue_vd_i,
  input  logic                  issue_src1_scalar_i,
  input  logic [ELEM_W-1:0]     issue_rs1_data_i,
  output logic                  vreg_re_o,
  output logic [4:0]            vreg_raddr1_o,
  output logic [4:0]            vreg_raddr2_o,
  input  logic [VREG_W-1:0]     vreg_rdata1_i,
  input  logic [VREG_W-1:0]     vreg_rdata2_i,
  output logic [ALU_OP_BUS-1:0] valu_opcode_o,
  output logic [VREG_W-1:0]     operand_v1_o,
  output logic [VREG_W-1:0]     operand_v2_o,
  input  logic [VREG_W-1:0]     valu_result_i,
  output logic                  vreg_we_o,
  output logic [4:0]            vreg_waddr_o,
  output logic [VREG_W-1:0]     vreg_wdata_o,
  output logic                  busy_o,
  output logic [31:0]           retire_cnt_o
);

  localparam int LANES = VREG_W / ELEM_W;
  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  vctrl_state_e        state_reg, state_next;
  valu_op_t            op_reg;
  logic [4:0]          vs1_reg, vs2_reg, vd_reg;
  logic                sel_reg;
  logic [ELEM_W-1:0]   scalar_reg;
  logic [VREG_W-1:0]   v1_reg, v2_reg, result_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [31:0]         retire_reg;
  logic [VREG_W-1:0]   bcast;
  logic                ready;
  logic                accept;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_bcast
      assign bcast[gi*ELEM_W +: ELEM_W] = scalar_reg;
    end
  endgenerate

  // Ready is gated by rst so the port reads 0 while reset is held, even though state is IDLE.
  assign ready  = !rst && (state_reg == VCTRL_IDLE || state_reg == VCTRL_WB);
  assign accept = issue_valid_i && ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      VCTRL_IDLE:  if (accept && issue_op_i != VALU_OP_NOP) state_next = VCTRL_READ;
      VCTRL_READ:  state_next = VCTRL_LATCH;
      VCTRL_LATCH: state_next = VCTRL_EXEC;
      VCTRL_EXEC:  if (cnt_reg == '0) state_next = VCTRL_WB;
      VCTRL_WB: begin
        state_next = VCTRL_IDLE;
        if (accept && issue_op_i != VALU_OP_NOP) state_next = VCTRL_READ;
      end
      default:     state_next = VCTRL_IDLE;
    endcase
  end

  always_comb begin
    issue_ready_o = ready;
    busy_o        = state_reg != VCTRL_IDLE;
    vreg_re_o     = 1'b0;
    vreg_raddr1_o = '0;
    vreg_raddr2_o = '0;
    valu_opcode_o = VALU_OP_NOP;
    operand_v1_o  = '0;
    operand_v2_o  = '0;
    vreg_we_o     = 1'b0;
    vreg_waddr_o  = '0;
    vreg_wdata_o  = '0;
    retire_cnt_o  = retire_reg;
    case (state_reg)
      VCTRL_READ: begin
        vreg_re_o     = 1'b1;
        vreg_raddr1_o = vs1_reg;
        vreg_raddr2_o = vs2_reg;
      end
      VCTRL_EXEC: begin
        valu_opcode_o = op_reg;
        operand_v1_o  = v1_reg;
        operand_v2_o  = v2_reg;
      end
      VCTRL_WB: begin
        vreg_we_o    = 1'b1;
        vreg_waddr_o = vd_reg;
        vreg_wdata_o = result_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= VCTRL_IDLE;
      op_reg     <= VALU_OP_NOP;
      vs1_reg    <= '0;
      vs2_reg    <= '0;
      vd_reg     <= '0;
      sel_reg    <= 1'b0;
      scalar_reg <= '0;
      v1_reg     <= '0;
      v2_reg     <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      retire_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg     <= issue_op_i;
        vs1_reg    <= issue_vs1_i;
        vs2_reg    <= issue_vs2_i;
        vd_reg     <= issue_vd_i;
        sel_reg    <= issue_src1_scalar_i;
        scalar_reg <= issue_rs1_data_i;
      end
      if (state_reg == VCTRL_LATCH) begin
        v2_reg  <= vreg_rdata2_i;
        v1_reg  <= sel_reg ? bcast : vreg_rdata1_i;
        cnt_reg <= is_div(op_reg) ? CNT_W'(DIV_LAT - 1) : '0;
      end
      // Operands stay frozen through EXEC; only the final cycle samples the ALU result.
      if (state_reg == VCTRL_EXEC) begin
        if (cnt_reg == '0) result_reg <= valu_result_i;
        else               cnt_reg    <= cnt_reg - 1'b1;
      end
      if (state_reg == VCTRL_WB) retire_reg <= retire_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_v_exec_ctrl.sv
// Directed bench for v_exec_ctrl with a behavioural register file and a small lane-wise ALU.
module tb_v_exec_ctrl;
  import v_exec_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_valid;
  logic               issue_ready;
  logic [4:0]         issue_op;
  logic [4:0]         issue_vs1, issue_vs2, issue_vd;
  logic               issue_src1_scalar;
  logic [31:0]        issue_rs1_data;
  logic               vreg_re;
  logic [4:0]         vreg_raddr1, vreg_raddr2;
  logic [127:0]       vreg_rdata1, vreg_rdata2;
  logic [4:0]         valu_opcode;
  logic [127:0]       operand_v1, operand_v2;
  logic [127:0]       valu_result;
  logic               vreg_we;
  logic [4:0]         vreg_waddr;
  logic [127:0]       vreg_wdata;
  logic               busy;
  logic [31:0]        retire_cnt;

  logic [127:0]       rf [32];
  logic               rf_init;
  logic signed [31:0] la, lb, lr;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  v_exec_ctrl #(.DIV_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_op_i(issue_op), .issue_vs1_i(issue_vs1), .issue_vs2_i(issue_vs2),
    .issue_vd_i(issue_vd), .issue_src1_scalar_i(issue_src1_scalar),
    .issue_rs1_data_i(issue_rs1_data),
    .vreg_re_o(vreg_re), .vreg_raddr1_o(vreg_raddr1), .vreg_raddr2_o(vreg_raddr2),
    .vreg_rdata1_i(vreg_rdata1), .vreg_rdata2_i(vreg_rdata2),
    .valu_opcode_o(valu_opcode), .operand_v1_o(operand_v1), .operand_v2_o(operand_v2),
    .valu_result_i(valu_result),
    .vreg_we_o(vreg_we), .vreg_waddr_o(vreg_waddr), .vreg_wdata_o(vreg_wdata),
    .busy_o(busy), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] bc(input logic [31:0] x);
    return {4{x}};
  endfunction

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf[2]  <= bc(32'd5);
      rf[3]  <= bc(32'd3);
      rf[5]  <= bc(-32'sd20);
      rf[6]  <= bc(32'd3);
      rf[10] <= DEAD;
    end else begin
      if (vreg_re) begin
        vreg_rdata1 <= rf[vreg_raddr1];
        vreg_rdata2 <= rf[vreg_raddr2];
      end
      if (vreg_we) rf[vreg_waddr] <= vreg_wdata;
    end
  end

  // Lane-wise ALU: v2 op v1 (vd = vs2 / vs1 for division).
  always_comb begin
    valu_result = '0;
    la = '0;
    lb = '0;
    lr = '0;
    for (int l = 0; l < 4; l++) begin
      la = operand_v1[l*32 +: 32];
      lb = operand_v2[l*32 +: 32];
      case (valu_opcode)
        VALU_OP_VADD:    lr = la + lb;
        VALU_OP_VDIV:    lr = (la == 0) ? 32'sd0 : lb / la;
        VALU_OP_VMV_V_X: lr = la;
        default:         lr = '0;
      endcase
      valu_result[l*32 +: 32] = lr;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [4:0] vd, input logic sel, input logic [31:0] scalar,
                       input logic hold);
    issue_op = op;
    issue_vs1 = vs1;
    issue_vs2 = vs2;
    issue_vd = vd;
    issue_src1_scalar = sel;
    issue_rs1_data = scalar;
    issue_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) issue_valid = 1'b0;
  endtask

  // Counts cycles after accept until vreg_we, and cycles the ALU sees the expected inputs.
  task automatic track(input logic [4:0] op, input logic [127:0] ev1, input logic [127:0] ev2,
                       output int lat, output int exec_cycles);
    lat = 0;
    exec_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (valu_opcode === op && operand_v1 === ev1 && operand_v2 === ev2) exec_cycles++;
    end while (vreg_we !== 1'b1 && lat < 30);
  endtask

  int lat, ex;
  logic [7:0] rpat;
  logic seen_re, seen_we, ready_low, seen_busy;

  initial begin
    rst = 1'b1;
    rf_init = 1'b1;
    issue_valid = 1'b0;
    issue_op = '0;
    issue_vs1 = '0;
    issue_vs2 = '0;
    issue_vd = '0;
    issue_src1_scalar = 1'b0;
    issue_rs1_data = '0;
    #2;
    chk("rst_ready", 128'(issue_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_retire", 128'(retire_cnt), 128'd0);
    repeat (2) @(negedge clk);
    rf_init = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle_ready", 128'(issue_ready), 128'd1);
    chk("idle_busy", 128'(busy), 128'd0);

    // VADD v4 = v2 + v3
    issue(VALU_OP_VADD, 5'd3, 5'd2, 5'd4, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("read_re", 128'(vreg_re), 128'd1);
    chk("read_raddr1", 128'(vreg_raddr1), 128'd3);
    chk("read_raddr2", 128'(vreg_raddr2), 128'd2);
    chk("read_ready", 128'(issue_ready), 128'd0);
    track(VALU_OP_VADD, bc(32'd3), bc(32'd5), lat, ex);
    chk("vadd_lat", 128'(lat + 1), 128'd4);
    chk("vadd_exec", 128'(ex), 128'd1);
    chk("vadd_waddr", 128'(vreg_waddr), 128'd4);
    chk("vadd_wdata", vreg_wdata, bc(32'd8));
    @(negedge clk);
    chk("vadd_retire", 128'(retire_cnt), 128'd1);
    chk("vadd_we_low", 128'(vreg_we), 128'd0);
    chk("vadd_opc_idle", 128'(valu_opcode), 128'd0);

    // VDIV v7 = v5 / v6, lanes -20 / 3
    issue(VALU_OP_VDIV, 5'd6, 5'd5, 5'd7, 1'b0, 32'd0, 1'b0);
    track(VALU_OP_VDIV, bc(32'd3), bc(-32'sd20), lat, ex);
    chk("vdiv_lat", 128'(lat), 128'd7);
    chk("vdiv_exec", 128'(ex), 128'd4);
    chk("vdiv_waddr", 128'(vreg_waddr), 128'd7);
    chk("vdiv_wdata", vreg_wdata, bc(32'hFFFF_FFFA));
    @(negedge clk);
    chk("vdiv_retire", 128'(retire_cnt), 128'd2);

    // VMV_V_X v8 = broadcast 7; vs1 register content must be ignored
    issue(VALU_OP_VMV_V_X, 5'd2, 5'd0, 5'd8, 1'b1, 32'h7, 1'b0);
    track(VALU_OP_VMV_V_X, bc(32'd7), 128'd0, lat, ex);
    chk("vmv_lat", 128'(lat), 128'd4);
    chk("vmv_exec", 128'(ex), 128'd1);
    chk("vmv_wdata", vreg_wdata, bc(32'd7));
    @(negedge clk);
    chk("vmv_retire", 128'(retire_cnt), 128'd3);

    // Back-to-back: v1 = v2 + v3, then v9 = v1 + v3 accepted in WB
    rpat = '0;
    issue(VALU_OP_VADD, 5'd3, 5'd2, 5'd1, 1'b0, 32'd0, 1'b1);
    issue_vs1 = 5'd3;
    issue_vs2 = 5'd1;
    issue_vd = 5'd9;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      rpat[i-1] = issue_ready;
      if (i == 4) begin
        chk("b2b_we1", 128'(vreg_we), 128'd1);
        chk("b2b_waddr1", 128'(vreg_waddr), 128'd1);
        chk("b2b_wdata1", vreg_wdata, bc(32'd8));
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
      end
      if (i == 5) chk("b2b_read2", 128'(vreg_raddr2), 128'd1);
    end
    chk("b2b_ready_pat", 128'(rpat), 128'h88);
    chk("b2b_we2", 128'(vreg_we), 128'd1);
    chk("b2b_waddr2", 128'(vreg_waddr), 128'd9);
    chk("b2b_wdata2", vreg_wdata, bc(32'd11));
    @(negedge clk);
    chk("b2b_retire", 128'(retire_cnt), 128'd5);

    // NOP: nothing happens
    seen_re = 1'b0;
    seen_we = 1'b0;
    ready_low = 1'b0;
    seen_busy = 1'b0;
    issue(VALU_OP_NOP, 5'd2, 5'd3, 5'd11, 1'b0, 32'd0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      seen_re |= vreg_re;
      seen_we |= vreg_we;
      ready_low |= !issue_ready;
      seen_busy |= busy;
    end
    chk("nop_re", 128'(seen_re), 128'd0);
    chk("nop_we", 128'(seen_we), 128'd0);
    chk("nop_ready", 128'(ready_low), 128'd0);
    chk("nop_busy", 128'(seen_busy), 128'd0);
    chk("nop_retire", 128'(retire_cnt), 128'd5);

    // Async reset in the middle of a VDIV EXEC window
    issue(VALU_OP_VDIV, 5'd6, 5'd5, 5'd10, 1'b0, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_pre_opc", 128'(valu_opcode), 128'(VALU_OP_VDIV));
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", 128'(issue_ready), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_opc", 128'(valu_opcode), 128'd0);
    chk("arst_v1", operand_v1, 128'd0);
    chk("arst_retire", 128'(retire_cnt), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_idle_ready", 128'(issue_ready), 128'd1);
    seen_we = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_we |= vreg_we;
    end
    chk("arst_no_we", 128'(seen_we), 128'd0);
    chk("arst_rf10", rf[10], DEAD);
    chk("arst_retire2", 128'(retire_cnt), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
